// File: rtl/clk_tick_pkg.sv
// Shared types and helpers for the multi-channel stopwatch timebase divider.
package clk_tick_pkg;

    localparam int DEF_WIDTH = 28;
    localparam logic [DEF_WIDTH-1:0] DEF_DIV = 28'd50_000_000;

    typedef logic [DEF_WIDTH-1:0] div_t;

    typedef enum logic [1:0] {
        LD_NONE = 2'd0,
        LD_ACK  = 2'd1,
        LD_ERR  = 2'd2
    } ld_res_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// One divider channel: phase counter, active/pending divisor, square clock and tick.
module clk_tick_chan import clk_tick_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV)
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             clock_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_r, div_active_r, pend_div_r;
    logic             pend_valid_r, clock_out_r, tick_r;
    logic [WIDTH-1:0] cnt_s, div_active_s, pend_div_s;
    logic             pend_valid_s, clock_out_s, tick_s, wrap_s;

    // Next-state selection: sync_clr, then disabled load, then normal counting.
    always_comb begin
        cnt_s        = cnt_r;
        div_active_s = div_active_r;
        pend_div_s   = pend_div_r;
        pend_valid_s = pend_valid_r;
        tick_s       = 1'b0;
        wrap_s       = enable && (cnt_r == (div_active_r - WIDTH'(1)));
        if (sync_clr) begin
            cnt_s = '0;
            if (load) begin
                div_active_s = load_value;
                pend_valid_s = 1'b0;
            end else if (pend_valid_r) begin
                div_active_s = pend_div_r;
                pend_valid_s = 1'b0;
            end else begin
                div_active_s = div_active_r;
            end
        end else if (!enable) begin
            if (load) begin
                div_active_s = load_value;
                cnt_s        = '0;
                pend_valid_s = 1'b0;
            end else begin
                cnt_s = cnt_r;
            end
        end else if (wrap_s) begin
            cnt_s  = '0;
            tick_s = 1'b1;
            // A load landing on the wrap edge bypasses the pending slot.
            if (load) begin
                div_active_s = load_value;
                pend_valid_s = 1'b0;
            end else if (pend_valid_r) begin
                div_active_s = pend_div_r;
                pend_valid_s = 1'b0;
            end else begin
                div_active_s = div_active_r;
            end
        end else begin
            cnt_s = cnt_r + WIDTH'(1);
            if (load) begin
                pend_div_s   = load_value;
                pend_valid_s = 1'b1;
            end else begin
                pend_valid_s = pend_valid_r;
            end
        end
        clock_out_s = (cnt_s < (div_active_s >> 1));
    end

    // Channel state and registered outputs.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_r        <= '0;
            div_active_r <= DEFAULT_DIV;
            pend_div_r   <= DEFAULT_DIV;
            pend_valid_r <= 1'b0;
            clock_out_r  <= 1'b1;
            tick_r       <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            div_active_r <= div_active_s;
            pend_div_r   <= pend_div_s;
            pend_valid_r <= pend_valid_s;
            clock_out_r  <= clock_out_s;
            tick_r       <= tick_s;
        end
    end

    assign clock_out = clock_out_r;
    assign tick      = tick_r;

endmodule

// File: rtl/clk_tick_gen.sv
// Runtime-programmable multi-channel clock/tick generator for the stopwatch timebase.
module clk_tick_gen import clk_tick_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM_CH = 2,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV)
) (
    input  logic                           clock_in,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              enable,
    input  logic                           sync_clr,
    input  logic                           div_load,
    input  logic [calc_ch_w(NUM_CH)-1:0]   div_ch,
    input  logic [WIDTH-1:0]               div_value,
    output logic                           load_ack,
    output logic                           load_err,
    output logic [NUM_CH-1:0]              clock_out,
    output logic [NUM_CH-1:0]              tick
);

    localparam int CH_W = calc_ch_w(NUM_CH);

    ld_res_t           ld_res_s;
    logic              ld_ok_s;
    logic [NUM_CH-1:0] ch_ld_s;
    logic              load_ack_r, load_err_r;

    // Validate the load request and steer it to exactly one channel.
    always_comb begin
        ld_ok_s  = ({{(32-CH_W){1'b0}}, div_ch} < 32'(NUM_CH)) &&
                   (div_value >= WIDTH'(2'd2));
        ld_res_s = LD_NONE;
        ch_ld_s  = '0;
        if (div_load) begin
            if (ld_ok_s) begin
                ld_res_s = LD_ACK;
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_ld_s[i] = (div_ch == CH_W'(i));
                end
            end else begin
                ld_res_s = LD_ERR;
            end
        end else begin
            ld_res_s = LD_NONE;
        end
    end

    // Handshake pulses, one cycle after the load strobe.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            load_ack_r <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            load_ack_r <= (ld_res_s == LD_ACK);
            load_err_r <= (ld_res_s == LD_ERR);
        end
    end

    assign load_ack = load_ack_r;
    assign load_err = load_err_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_tick_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock_in   (clock_in),
            .reset      (reset),
            .enable     (enable[g]),
            .sync_clr   (sync_clr),
            .load       (ch_ld_s[g]),
            .load_value (div_value),
            .clock_out  (clock_out[g]),
            .tick       (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: period-level model plus directed scenarios.
module tb_clk_tick_gen;

    localparam int NCH = 2;
    localparam int DEF = 4;

    logic            clock_in;
    logic            reset, sync_clr, div_load;
    logic [NCH-1:0]  enable;
    logic [0:0]      div_ch;
    logic [27:0]     div_value;
    logic            load_ack, load_err;
    logic [NCH-1:0]  clock_out, tick;

    logic [2:0]      d3_en;
    logic            d3_load;
    logic [1:0]      d3_ch;
    logic [7:0]      d3_val;
    logic            d3_ack, d3_err;
    logic [2:0]      d3_clk, d3_tick;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    int m_pos[NCH], m_d[NCH], m_pd[NCH];
    bit m_pv[NCH], m_tick[NCH];
    bit m_ack, m_err;

    clk_tick_gen #(.WIDTH(28), .NUM_CH(NCH), .DEFAULT_DIV(28'd4)) u_dut (
        .clock_in(clock_in), .reset(reset), .enable(enable), .sync_clr(sync_clr),
        .div_load(div_load), .div_ch(div_ch), .div_value(div_value),
        .load_ack(load_ack), .load_err(load_err), .clock_out(clock_out), .tick(tick)
    );

    // Three channels so that an out-of-range channel number is representable.
    clk_tick_gen #(.WIDTH(8), .NUM_CH(3), .DEFAULT_DIV(8'd4)) u_dut3 (
        .clock_in(clock_in), .reset(reset), .enable(d3_en), .sync_clr(1'b0),
        .div_load(d3_load), .div_ch(d3_ch), .div_value(d3_val),
        .load_ack(d3_ack), .load_err(d3_err), .clock_out(d3_clk), .tick(d3_tick)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a loaded divisor is queued and takes over when the running period
    // completes; a disabled channel or sync_clr takes it at once.
    task automatic model_step();
        bit vld, ld;
        vld = (int'(div_ch) < NCH) && (div_value >= 28'd2);
        if (reset) begin
            m_ack = 0; m_err = 0;
            for (int i = 0; i < NCH; i++) begin
                m_pos[i] = 0; m_d[i] = DEF; m_pv[i] = 0; m_tick[i] = 0;
            end
        end else begin
            m_ack = div_load && vld;
            m_err = div_load && !vld;
            for (int i = 0; i < NCH; i++) begin
                ld = div_load && vld && (int'(div_ch) == i);
                m_tick[i] = 0;
                if (sync_clr) begin
                    m_pos[i] = 0;
                    if (ld) begin m_d[i] = int'(div_value); m_pv[i] = 0; end
                    else if (m_pv[i]) begin m_d[i] = m_pd[i]; m_pv[i] = 0; end
                end else if (!enable[i]) begin
                    if (ld) begin m_d[i] = int'(div_value); m_pos[i] = 0; m_pv[i] = 0; end
                end else begin
                    if (ld) begin m_pd[i] = int'(div_value); m_pv[i] = 1; end
                    m_pos[i]++;
                    if (m_pos[i] == m_d[i]) begin
                        m_pos[i] = 0;
                        m_tick[i] = 1;
                        if (m_pv[i]) begin m_d[i] = m_pd[i]; m_pv[i] = 0; end
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock_in);
        model_step();
    end

    initial forever begin
        @(negedge clock_in);
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("model_clk%0d", i), 32'(clock_out[i]), 32'(m_pos[i] < m_d[i] / 2));
                chk($sformatf("model_tick%0d", i), 32'(tick[i]), 32'(m_tick[i]));
            end
            chk("model_ack", 32'(load_ack), 32'(m_ack));
            chk("model_err", 32'(load_err), 32'(m_err));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic capture(input int ch, input int n, output logic [15:0] cp, output logic [15:0] tp);
        cp = '0; tp = '0;
        for (int j = 0; j < n; j++) begin
            cp[j] = clock_out[ch];
            tp[j] = tick[ch];
            if (j < n - 1) cyc(1);
        end
    endtask

    task automatic wait_pos(input int ch, input int p, input string nm);
        for (int k = 0; k < 40 && m_pos[ch] != p; k++) cyc(1);
        if (m_pos[ch] != p) chk(nm, 32'(m_pos[ch]), 32'(p));
    endtask

    task automatic tick_period(input int ch, output int per);
        per = -1;
        for (int k = 0; k < 40 && tick[ch] !== 1'b1; k++) cyc(1);
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (tick[ch] === 1'b1) begin per = k; break; end
        end
    endtask

    task automatic reset_and_pattern(input string tag);
        logic [15:0] cp, tp;
        reset = 1'b1;
        cyc(2);
        chk({tag, "_rst_clk"}, 32'(clock_out), 32'h3);
        chk({tag, "_rst_tick"}, 32'(tick), 32'h0);
        reset = 1'b0;
        enable = 2'b11;
        for (int c = 0; c < NCH; c++) begin
            if (c > 0) begin
                reset = 1'b1; cyc(1); reset = 1'b0;
            end
            capture(c, 8, cp, tp);
            chk($sformatf("%s_pat_clk%0d", tag, c), 32'(cp), 32'h0033);
            chk($sformatf("%s_pat_tick%0d", tag, c), 32'(tp), 32'h0010);
        end
    endtask

    initial begin
        logic [15:0] cp, tp;
        int per, acks;
        reset = 1'b1; enable = '0; sync_clr = 1'b0; div_load = 1'b0;
        div_ch = 1'b0; div_value = 28'd0;
        d3_en = 3'b000; d3_load = 1'b0; d3_ch = 2'd0; d3_val = 8'd6;
        cyc(1);
        chk_en = 1;

        // Reset state and the default 4-cycle pattern on both channels.
        reset_and_pattern("s1");

        // Odd divisor loaded while disabled: high 2, low 3.
        enable = 2'b10;
        cyc(1);
        div_load = 1'b1; div_ch = 1'b0; div_value = 28'd5;
        cyc(1);
        chk("s2_ack", 32'(load_ack), 32'h1);
        div_load = 1'b0;
        enable = 2'b11;
        capture(0, 10, cp, tp);
        chk("s2_pat_clk", 32'(cp), 32'h0063);
        chk("s2_pat_tick", 32'(tp), 32'h0020);

        // Pending load on ch1 at phase 1: D=4 finishes, then D=6.
        wait_pos(1, 1, "s3_wait_pos");
        cp = '0; tp = '0;
        for (int j = 0; j < 10; j++) begin
            cp[j] = clock_out[1];
            tp[j] = tick[1];
            if (j == 0) begin div_load = 1'b1; div_ch = 1'b1; div_value = 28'd6; end
            if (j == 1) begin
                chk("s3_ack", 32'(load_ack), 32'h1);
                div_load = 1'b0;
            end
            if (j < 9) cyc(1);
        end
        chk("s3_pat_clk", 32'(cp), 32'h0239);
        chk("s3_pat_tick", 32'(tp), 32'h0208);

        // Two loads before the wrap: last one wins, both acknowledged.
        acks = 0;
        div_load = 1'b1; div_ch = 1'b1; div_value = 28'd8;
        cyc(1);
        acks += int'(load_ack);
        div_value = 28'd6;
        cyc(1);
        acks += int'(load_ack);
        div_load = 1'b0;
        chk("s3_two_acks", 32'(acks), 32'd2);
        tick_period(1, per);
        chk("s3_last_wins_period", 32'(per), 32'd6);

        // Illegal loads: divisor below 2, and channel beyond NUM_CH.
        div_load = 1'b1; div_ch = 1'b0; div_value = 28'd1;
        d3_load = 1'b1; d3_ch = 2'd3;
        cyc(1);
        chk("s4_err_div1", 32'(load_err), 32'h1);
        chk("s4_noack_div1", 32'(load_ack), 32'h0);
        chk("s4_err_ch3", 32'(d3_err), 32'h1);
        chk("s4_noack_ch3", 32'(d3_ack), 32'h0);
        div_load = 1'b0;
        d3_ch = 2'd2;
        cyc(1);
        chk("s4_ack_ch2", 32'(d3_ack), 32'h1);
        chk("s4_noerr_ch2", 32'(d3_err), 32'h0);
        d3_load = 1'b0;
        tick_period(0, per);
        chk("s4_ch0_period", 32'(per), 32'd5);

        // Freeze ch0 at phase 2 for three cycles, then sync_clr.
        wait_pos(0, 2, "s5_wait_pos");
        enable = 2'b10;
        for (int j = 0; j < 3; j++) begin
            cyc(1);
            chk("s5_frozen_clk", 32'(clock_out[0]), 32'h0);
            chk("s5_frozen_tick", 32'(tick[0]), 32'h0);
        end
        sync_clr = 1'b1; enable = 2'b11;
        cyc(1);
        chk("s5_clr_clk", 32'(clock_out), 32'h3);
        chk("s5_clr_tick", 32'(tick), 32'h0);
        sync_clr = 1'b0;

        // Reset with a pending divisor on ch0: the pending value is dropped.
        cyc(2);
        div_load = 1'b1; div_ch = 1'b0; div_value = 28'd7;
        cyc(1);
        div_load = 1'b0;
        reset_and_pattern("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
